// File: rtl/vga_pkg.sv
// Shared constants, register map and FSM encoding for the vblank commit controller.
package vga_pkg;

  localparam int HACTIVE = 1280;
  localparam int VACTIVE = 480;
  localparam int SCALE   = 5;

  typedef enum logic [2:0] {
    ADDR_RED     = 3'd0,
    ADDR_GREEN   = 3'd1,
    ADDR_BLUE    = 3'd2,
    ADDR_H_START = 3'd3,
    ADDR_H_END   = 3'd4,
    ADDR_V_START = 3'd5,
    ADDR_V_END   = 3'd6,
    ADDR_CTRL    = 3'd7
  } reg_addr_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Geometry registers hold the byte written by software times SCALE (max 1275).
  function automatic logic [10:0] scale_geom(input logic [7:0] raw);
    return {3'b000, raw} * 11'(SCALE);
  endfunction

endpackage

// File: rtl/vblank_commit_ctrl_if.sv
// Avalon-MM slave bus used to program the vblank commit controller.
interface vblank_commit_ctrl_if;
  logic       chipselect;
  logic       write;
  logic       read;
  logic [2:0] address;
  logic [7:0] writedata;
  logic [7:0] readdata;

  modport master (output chipselect, write, read, address, writedata, input readdata);
  modport slave  (input chipselect, write, read, address, writedata, output readdata);
endinterface

// File: rtl/vblank_detect.sv
// Derives the vertical-blank start pulse and level from the raster counters.
// The pulse is edge-qualified so a stalled raster counter cannot re-trigger it.
module vblank_detect
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic        vblank_start,
  output logic        in_vblank
);

  logic match_s;
  logic match_r;

  assign match_s      = (vcount == 10'(VACTIVE)) && (hcount == 11'd0);
  assign vblank_start = match_s & ~match_r;
  assign in_vblank    = (vcount >= 10'(VACTIVE));

  // Remember last cycle's raster match so only its first cycle pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_r <= 1'b0;
    end else begin
      match_r <= match_s;
    end
  end

endmodule

// File: rtl/vblank_commit_ctrl.sv
// Double-buffered background/ball-box registers committed atomically at vblank.
// Optional feature macro: VBLANK_COMMIT_IRQ_EN (sticky commit-done interrupt).
module vblank_commit_ctrl
  import vga_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  vblank_commit_ctrl_if.slave  bus,
  input  logic [10:0]          hcount,
  input  logic [9:0]           vcount,
  output logic [7:0]           bg_r,
  output logic [7:0]           bg_g,
  output logic [7:0]           bg_b,
  output logic [10:0]          h_start,
  output logic [10:0]          h_end,
  output logic [10:0]          v_start,
  output logic [10:0]          v_end,
  output logic                 irq
);

  logic       vblank_start_s;
  logic       in_vblank_s;
  logic       wr_s;
  logic       rd_s;
  logic       arm_s;
  logic       clr_s;
  logic       geom_err_s;
  logic [7:0] status_s;

  // Shadow bank keeps the raw bytes written by software.
  logic [7:0] sh_red_r, sh_green_r, sh_blue_r;
  logic [7:0] sh_hs_r, sh_he_r, sh_vs_r, sh_ve_r;

  // Active bank drives the outputs.
  logic [7:0]  act_red_r, act_green_r, act_blue_r;
  logic [10:0] act_hs_r, act_he_r, act_vs_r, act_ve_r;

  state_e      state_r;
  logic [7:0]  frame_count_r;
  logic        irq_r;
  logic [7:0]  readdata_r;

  vblank_detect u_vblank_detect (
    .clk          (clk),
    .reset_n      (reset_n),
    .hcount       (hcount),
    .vcount       (vcount),
    .vblank_start (vblank_start_s),
    .in_vblank    (in_vblank_s)
  );

  assign wr_s  = bus.chipselect & bus.write;
  assign rd_s  = bus.chipselect & bus.read;
  assign arm_s = wr_s && (bus.address == ADDR_CTRL) && bus.writedata[0];
`ifdef VBLANK_COMMIT_IRQ_EN
  assign clr_s = wr_s && (bus.address == ADDR_CTRL) && bus.writedata[1];
`else
  assign clr_s = 1'b0;
`endif

  // Scaling is monotonic, so comparing raw bytes matches comparing scaled values.
  assign geom_err_s = (sh_hs_r > sh_he_r) || (sh_vs_r > sh_ve_r);
  assign status_s   = {frame_count_r[3:0], geom_err_s, in_vblank_s, irq_r,
                       (state_r == ST_ARMED)};

  assign bg_r          = act_red_r;
  assign bg_g          = act_green_r;
  assign bg_b          = act_blue_r;
  assign h_start       = act_hs_r;
  assign h_end         = act_he_r;
  assign v_start       = act_vs_r;
  assign v_end         = act_ve_r;
  assign irq           = irq_r;
  assign bus.readdata  = readdata_r;

  // Capture software writes into the shadow bank; the control address holds no data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_red_r   <= 8'h00;
      sh_green_r <= 8'h00;
      sh_blue_r  <= 8'h80;
      sh_hs_r    <= 8'h00;
      sh_he_r    <= 8'h00;
      sh_vs_r    <= 8'h00;
      sh_ve_r    <= 8'h00;
    end else if (wr_s) begin
      case (bus.address)
        ADDR_RED:     sh_red_r   <= bus.writedata;
        ADDR_GREEN:   sh_green_r <= bus.writedata;
        ADDR_BLUE:    sh_blue_r  <= bus.writedata;
        ADDR_H_START: sh_hs_r    <= bus.writedata;
        ADDR_H_END:   sh_he_r    <= bus.writedata;
        ADDR_V_START: sh_vs_r    <= bus.writedata;
        ADDR_V_END:   sh_ve_r    <= bus.writedata;
        default:      sh_red_r   <= sh_red_r;
      endcase
    end
  end

  // Commit FSM; the active bank loads from shadow only during the COMMIT cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      act_red_r   <= 8'h00;
      act_green_r <= 8'h00;
      act_blue_r  <= 8'h80;
      act_hs_r    <= 11'd0;
      act_he_r    <= 11'd0;
      act_vs_r    <= 11'd0;
      act_ve_r    <= 11'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // An arm coinciding with vblank only arms; the commit waits a frame.
          if (arm_s) state_r <= ST_ARMED;
        end
        ST_ARMED: begin
          if (vblank_start_s) state_r <= ST_COMMIT;
        end
        ST_COMMIT: begin
          act_red_r   <= sh_red_r;
          act_green_r <= sh_green_r;
          act_blue_r  <= sh_blue_r;
          act_hs_r    <= scale_geom(sh_hs_r);
          act_he_r    <= scale_geom(sh_he_r);
          act_vs_r    <= scale_geom(sh_vs_r);
          act_ve_r    <= scale_geom(sh_ve_r);
          state_r     <= arm_s ? ST_ARMED : ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Count frames at every vblank start, wrapping naturally at 8 bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count_r <= 8'd0;
    end else if (vblank_start_s) begin
      frame_count_r <= frame_count_r + 8'd1;
    end
  end

  // Sticky commit-done interrupt; a commit wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_r <= 1'b0;
    end else if (state_r == ST_COMMIT) begin
`ifdef VBLANK_COMMIT_IRQ_EN
      irq_r <= 1'b1;
`else
      irq_r <= 1'b0;
`endif
    end else if (clr_s) begin
      irq_r <= 1'b0;
    end
  end

  // Registered read port: shadow bytes at 0-6, status at the control address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_r <= 8'h00;
    end else if (rd_s) begin
      case (bus.address)
        ADDR_RED:     readdata_r <= sh_red_r;
        ADDR_GREEN:   readdata_r <= sh_green_r;
        ADDR_BLUE:    readdata_r <= sh_blue_r;
        ADDR_H_START: readdata_r <= sh_hs_r;
        ADDR_H_END:   readdata_r <= sh_he_r;
        ADDR_V_START: readdata_r <= sh_vs_r;
        ADDR_V_END:   readdata_r <= sh_ve_r;
        ADDR_CTRL:    readdata_r <= status_s;
        default:      readdata_r <= 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_vblank_commit_ctrl.sv
// Directed self-checking bench for vblank_commit_ctrl (default and IRQ builds).
module tb_vblank_commit_ctrl;

`ifdef VBLANK_COMMIT_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [7:0]  bg_r, bg_g, bg_b;
  logic [10:0] h_start, h_end, v_start, v_end;
  logic        irq;

  int          n_tests;
  int          n_fail;
  logic [7:0]  exp_fc;
  int          n_wrap;

  vblank_commit_ctrl_if bus_if ();

  vblank_commit_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if),
    .hcount  (hcount),
    .vcount  (vcount),
    .bg_r    (bg_r),
    .bg_g    (bg_g),
    .bg_b    (bg_b),
    .h_start (h_start),
    .h_end   (h_end),
    .v_start (v_start),
    .v_end   (v_end),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] stat(input logic [3:0] fc, input logic ge,
                                      input logic inv, input logic irqv, input logic armed);
    return {fc, ge, inv, irqv, armed};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
    bus_if.chipselect = 1'b1;
    bus_if.write      = 1'b1;
    bus_if.address    = a;
    bus_if.writedata  = d;
    tick();
    bus_if.chipselect = 1'b0;
    bus_if.write      = 1'b0;
  endtask

  task automatic bus_rd_check(input string tag, input logic [2:0] a, input logic [7:0] exp);
    bus_if.chipselect = 1'b1;
    bus_if.read       = 1'b1;
    bus_if.address    = a;
    tick();
    bus_if.chipselect = 1'b0;
    bus_if.read       = 1'b0;
    check_eq(tag, {8'h00, bus_if.readdata}, {8'h00, exp});
  endtask

  // One raster cycle at line 480 / pixel 0; afterwards the raster is parked off-match.
  task automatic vblank_pulse();
    vcount = 10'd480;
    hcount = 11'd0;
    tick();
    exp_fc = exp_fc + 8'd1;
    vcount = 10'd0;
    hcount = 11'd5;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_fc  = 8'd0;
    reset_n = 1'b0;
    hcount  = 11'd5;
    vcount  = 10'd0;
    bus_if.chipselect = 1'b0;
    bus_if.write      = 1'b0;
    bus_if.read       = 1'b0;
    bus_if.address    = 3'd0;
    bus_if.writedata  = 8'h00;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Reset state
    check_eq("rst_bg_r", {8'h00, bg_r}, 16'h0000);
    check_eq("rst_bg_g", {8'h00, bg_g}, 16'h0000);
    check_eq("rst_bg_b", {8'h00, bg_b}, 16'h0080);
    check_eq("rst_h_start", {5'd0, h_start}, 16'd0);
    check_eq("rst_v_end", {5'd0, v_end}, 16'd0);
    check_eq("rst_irq", {15'd0, irq}, 16'd0);
    bus_rd_check("rst_status", 3'd7, 8'h00);
    bus_rd_check("rst_shadow_b", 3'd2, 8'h80);

    // Commit timing
    bus_wr(3'd3, 8'd10);
    bus_wr(3'd4, 8'd20);
    bus_wr(3'd7, 8'h01);
    check_eq("armed_h_start", {5'd0, h_start}, 16'd0);
    bus_rd_check("armed_status", 3'd7, stat(exp_fc[3:0], 1'b0, 1'b0, 1'b0, 1'b1));
    vblank_pulse();
    check_eq("commit_cycle_h_start", {5'd0, h_start}, 16'd0);
    tick();
    check_eq("post_commit_h_start", {5'd0, h_start}, 16'd50);
    check_eq("post_commit_h_end", {5'd0, h_end}, 16'd100);
    check_eq("post_commit_irq", {15'd0, irq}, {15'd0, IRQ_EN});
    bus_rd_check("raw_readback_h_start", 3'd3, 8'd10);
    bus_rd_check("idle_status", 3'd7, stat(exp_fc[3:0], 1'b0, 1'b0, IRQ_EN, 1'b0));

    // Late write in the COMMIT cycle reaches shadow only
    bus_wr(3'd7, 8'h01);
    vblank_pulse();
    bus_wr(3'd0, 8'hFF);
    check_eq("late_write_bg_r", {8'h00, bg_r}, 16'h0000);
    bus_rd_check("late_write_status", 3'd7, stat(exp_fc[3:0], 1'b0, 1'b0, IRQ_EN, 1'b0));
    bus_wr(3'd7, 8'h01);
    vblank_pulse();
    tick();
    check_eq("rearm_bg_r", {8'h00, bg_r}, 16'h00FF);

    // Arm in the COMMIT cycle re-arms
    bus_wr(3'd7, 8'h01);
    vblank_pulse();
    bus_wr(3'd7, 8'h01);
    bus_rd_check("commit_rearm_status", 3'd7, stat(exp_fc[3:0], 1'b0, 1'b0, IRQ_EN, 1'b1));
    vblank_pulse();
    tick();

    // Arm coincident with vblank while IDLE only arms
    bus_wr(3'd1, 8'h33);
    vcount = 10'd480;
    hcount = 11'd0;
    bus_wr(3'd7, 8'h01);
    exp_fc = exp_fc + 8'd1;
    vcount = 10'd0;
    hcount = 11'd5;
    tick();
    check_eq("coincident_arm_no_commit", {8'h00, bg_g}, 16'h0000);
    bus_rd_check("coincident_arm_status", 3'd7, stat(exp_fc[3:0], 1'b0, 1'b0, IRQ_EN, 1'b1));
    vblank_pulse();
    tick();
    check_eq("coincident_next_frame_bg_g", {8'h00, bg_g}, 16'h0033);

    // IRQ: set wins over simultaneous clear, clear alone drops it
    bus_wr(3'd7, 8'h01);
    vblank_pulse();
    bus_wr(3'd7, 8'h02);
    check_eq("irq_set_wins", {15'd0, irq}, {15'd0, IRQ_EN});
    bus_wr(3'd7, 8'h02);
    check_eq("irq_cleared", {15'd0, irq}, 16'd0);

    // Geometry error still commits
    bus_wr(3'd3, 8'd30);
    bus_wr(3'd4, 8'd10);
    bus_rd_check("geom_err_status", 3'd7, stat(exp_fc[3:0], 1'b1, 1'b0, 1'b0, 1'b0));
    bus_wr(3'd7, 8'h01);
    vblank_pulse();
    tick();
    check_eq("geom_err_h_start", {5'd0, h_start}, 16'd150);
    check_eq("geom_err_h_end", {5'd0, h_end}, 16'd50);

    // Frame counter wrap
    n_wrap = 256 - int'(exp_fc);
    for (int i = 0; i < n_wrap; i++) begin
      vblank_pulse();
      tick();
    end
    check_eq("frame_count_wrap", {8'h00, dut.frame_count_r}, {8'h00, exp_fc});
    check_eq("frame_count_is_zero", {8'h00, dut.frame_count_r}, 16'h0000);
    bus_rd_check("wrap_status", 3'd7, stat(exp_fc[3:0], 1'b1, 1'b0, IRQ_EN, 1'b0));

    // in_vblank level
    vcount = 10'd500;
    bus_rd_check("in_vblank_status", 3'd7, stat(exp_fc[3:0], 1'b1, 1'b1, IRQ_EN, 1'b0));
    vcount = 10'd0;

    // Reset while armed abandons the commit
    bus_wr(3'd0, 8'h11);
    bus_wr(3'd7, 8'h01);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    exp_fc = 8'd0;
    tick();
    check_eq("midrst_bg_r", {8'h00, bg_r}, 16'h0000);
    check_eq("midrst_bg_b", {8'h00, bg_b}, 16'h0080);
    check_eq("midrst_h_start", {5'd0, h_start}, 16'd0);
    check_eq("midrst_irq", {15'd0, irq}, 16'd0);
    bus_rd_check("midrst_status", 3'd7, 8'h00);
    vblank_pulse();
    tick();
    check_eq("midrst_no_commit_bg_r", {8'h00, bg_r}, 16'h0000);
    bus_rd_check("midrst_status_idle", 3'd7, stat(exp_fc[3:0], 1'b0, 1'b0, 1'b0, 1'b0));
    bus_rd_check("midrst_shadow_r", 3'd0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vblank_commit_ctrl.md
VBLANK_COMMIT_CTRL -- requirements
Module: vblank_commit_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, 50 MHz, all logic on rising edge.
REQ-002 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: chipselect  in  1  Avalon slave select.
REQ-004 SHALL have ports: write, read  in  1 each  Avalon strobes, qualified by chipselect.
REQ-005 SHALL have ports: address  in  3  register index; writedata  in  8  write data.
REQ-006 SHALL have ports: readdata  out  8  registered read data.
REQ-007 SHALL have ports: hcount  in  11 and vcount  in  10  raster position from the VGA counters.
REQ-008 SHALL have ports: bg_r, bg_g, bg_b  out  8 each  active background colour.
REQ-009 SHALL have ports: h_start, h_end, v_start, v_end  out  11 each  active ball box.
REQ-010 SHALL have ports: irq  out  1  commit-done interrupt.

Function
REQ-011 SHALL keep a shadow bank and an active bank of seven registers; Avalon writes to addresses 0-6 go to the shadow bank only (0 r, 1 g, 2 b, 3 h_start, 4 h_end, 5 v_start, 6 v_end).
REQ-012 SHALL store geometry writes as writedata*5, zero-extended to 11 bits (max 1275); colour writes unscaled.
REQ-013 SHALL drive all outputs from the active bank, which changes only in the COMMIT state.
REQ-014 SHALL generate vblank_start as a one-cycle pulse when vcount==480 and hcount==0.
REQ-015 SHALL implement FSM IDLE, ARMED, COMMIT: IDLE->ARMED on write to address 7 with writedata[0]=1; ARMED->COMMIT on vblank_start; COMMIT->IDLE after one cycle.
REQ-016 SHALL copy all seven shadow registers to the active bank in the single COMMIT cycle.
REQ-017 A shadow write during ARMED SHALL be committed; a shadow write in the COMMIT cycle SHALL update shadow only, not the active bank.
REQ-018 An arm request while ARMED SHALL have no effect; an arm request in the COMMIT cycle SHALL make the next state ARMED.
REQ-019 An arm request coincident with vblank_start while IDLE SHALL arm only, with the commit at the next frame.
REQ-020 SHALL keep an 8-bit frame_count, incremented on every vblank_start and wrapping 255->0.
REQ-021 Reads SHALL return data on readdata one cycle after read&chipselect. Addresses 0-6 return the shadow raw writedata (unscaled). Address 7 returns {frame_count[3:0], geom_err, in_vblank, irq, armed}.
REQ-022 SHALL set geom_err when shadow h_start>h_end or v_start>v_end; the commit still proceeds unchanged.
REQ-023 in_vblank SHALL be 1 when vcount>=480.

Reset
REQ-024 On reset_n low, both banks SHALL take r=0x00, g=0x00, b=0x80 and geometry 0; FSM IDLE; frame_count 0; irq 0; readdata 0.
REQ-025 Reset asserted mid-ARMED or mid-COMMIT SHALL abandon the commit; the active bank returns to reset values.

Configuration
REQ-026 With macro VBLANK_COMMIT_IRQ_EN defined, irq SHALL be set sticky in the COMMIT cycle and cleared by a write to address 7 with writedata[1]=1; set wins over a simultaneous clear.
REQ-027 Without VBLANK_COMMIT_IRQ_EN, irq and status bit 1 SHALL be constant 0, and writedata[1] SHALL be ignored.

Structure
REQ-028 Package vga_pkg SHALL hold HACTIVE=1280, VACTIVE=480, the SCALE=5 constant, the register address enum, and the FSM state enum.
REQ-029 Sub-module vblank_detect SHALL produce vblank_start and in_vblank from hcount/vcount; all other logic stays in vblank_commit_ctrl.

Verification
REQ-030 Reset check: after reset, bg = 00/00/80, geometry 0, readdata at address 7 = 0x00.
REQ-031 Commit timing: write addr3=10, addr4=20, then arm -> h_start stays 0 until the cycle after vcount=480/hcount=0, then h_start=50 and h_end=100.
REQ-032 Late write: write addr0=0xFF in the COMMIT cycle -> bg_r unchanged after commit; re-arm -> bg_r=0xFF after the next vblank.
REQ-033 Wrap and status: run 256 frames -> frame_count wraps to 0. Write addr3=30, addr4=10 -> status geom_err=1, and a commit still applies h_start=150.
REQ-034 IRQ: with VBLANK_COMMIT_IRQ_EN, a commit sets irq=1; a clear write coincident with a second commit leaves irq=1; a clear write alone gives irq=0.
REQ-035 Reset mid-operation: arm, then pulse reset_n low before vblank -> no commit occurs, state IDLE, active bank at reset values.
